md_sequencer: RTL

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer for the E stage.
// Latches operands on accept, holds busy for a fixed cycle count, then commits.
`timescale 1ns/1ps
module md_sequencer #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MCYC = 4'(MULT_CYC);
  localparam logic [3:0] DCYC = 4'(DIV_CYC);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        sgn_q;
  logic        div_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic [63:0] prod_d;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q_d;
  logic [31:0] r_d;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        wr_d;

  // Signed divide via magnitudes so overflow (MIN / -1) wraps cleanly.
  always_comb begin
    if (sgn_q) begin
      prod_d = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    end else begin
      prod_d = {32'b0, a_q} * {32'b0, b_q};
    end
    abs_a = (sgn_q && a_q[31]) ? -a_q : a_q;
    abs_b = (sgn_q && b_q[31]) ? -b_q : b_q;
    uq = '0;
    ur = '0;
    if (b_q != 32'b0) begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
    q_d = (sgn_q && (a_q[31] ^ b_q[31])) ? -uq : uq;
    r_d = (sgn_q && a_q[31]) ? -ur : ur;
    if (div_q) begin
      hi_d = r_d;
      lo_d = q_d;
      wr_d = (b_q != 32'b0);
    end else begin
      hi_d = prod_d[63:32];
      lo_d = prod_d[31:0];
      wr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      div_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            unique case (1'b1)
              !op[2]: begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                cnt_q   <= op[1] ? DCYC : MCYC;
                sgn_q   <= ~op[0];
                div_q   <= op[1];
                a_q     <= rs;
                b_q     <= rt;
              end
              (op == 3'd4): hi_q <= rs;
              (op == 3'd5): lo_q <= rs;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (wr_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
